aquarium_param_writer: RTL

Write-side controller for the aquarium monitor's five tank parameter registers: fish count, cleanliness, temperature, food storage and saltiness. It accepts one write command at a time over a valid/ready handshake and routes the 8-bit data into the register selected by the mode code. It uses the same 5-bit mode encoding that the readout multiplexer uses on the read side. It holds the five parameter values and presents them continuously as outputs, so the existing select/mux read path can consume them unchanged.

---
 rtl/aquarium_param_writer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/aquarium_param_writer.sv
// aquarium_param_writer
//   Write-side controller for the five tank parameter registers of the
//   aquarium monitor. One command at a time is accepted over wr_valid /
//   wr_ready, executed one cycle later, and acknowledged with a one-cycle
//   wr_done pulse. The stored values are presented continuously on Q_*.
//
//   Ports
//     CLK       : clock, rising edge
//     reset     : asynchronous, active-low
//     wr_valid  : command present           wr_ready : FSM idle
//     wr_mode   : 5-bit target code         wr_data  : 8-bit value
//     wr_done   : completion pulse          wr_err   : sticky error flag
//     err_clr   : clears wr_err (a same-cycle new error wins)
//     Q_fish/Q_clean/Q_temp/Q_food/Q_salt : stored parameter values
//     wr_count  : saturating count of successful writes
//
//   Build option
//     AQ_RANGE_CHECK_EN : when defined, temperature writes outside
//                         [TEMP_MIN, TEMP_MAX] are rejected with wr_err.
module aquarium_param_writer #(
    parameter logic [7:0] TEMP_MIN = 8'd20,
    parameter logic [7:0] TEMP_MAX = 8'd30
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_mode,
    input  logic [7:0] wr_data,
    output logic       wr_done,
    output logic       wr_err,
    input  logic       err_clr,
    output logic [7:0] Q_fish,
    output logic [7:0] Q_clean,
    output logic [7:0] Q_temp,
    output logic [7:0] Q_food,
    output logic [7:0] Q_salt,
    output logic [7:0] wr_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state_q, state_d;
    logic [4:0]      cmd_mode_q, cmd_mode_d;
    logic [7:0]      cmd_data_q, cmd_data_d;
    // Parameter file, index 0..4 = fish, clean, temp, food, salt
    // (same bit order as the one-hot mode code).
    logic [4:0][7:0] par_q, par_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            temp_ok;
    logic            cnt_inc;
    logic            err_set;

`ifdef AQ_RANGE_CHECK_EN
    assign temp_ok = (cmd_data_q >= TEMP_MIN) && (cmd_data_q <= TEMP_MAX);
`else
    assign temp_ok = 1'b1;
    // Bounds only matter in the range-checked build.
    logic unused_temp_bounds;
    assign unused_temp_bounds = ^{TEMP_MIN, TEMP_MAX};
`endif

    always_comb begin
        state_d    = state_q;
        cmd_mode_d = cmd_mode_q;
        cmd_data_d = cmd_data_q;
        par_d      = par_q;
        cnt_inc    = 1'b0;
        err_set    = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    cmd_mode_d = wr_mode;
                    cmd_data_d = wr_data;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                state_d = DONE;
                case (cmd_mode_q)
                    5'b00000: ;
                    5'b00001: begin par_d[0] = cmd_data_q; cnt_inc = 1'b1; end
                    5'b00010: begin par_d[1] = cmd_data_q; cnt_inc = 1'b1; end
                    5'b00100: begin
                        if (temp_ok) begin
                            par_d[2] = cmd_data_q;
                            cnt_inc  = 1'b1;
                        end else begin
                            err_set  = 1'b1;
                        end
                    end
                    5'b01000: begin par_d[3] = cmd_data_q; cnt_inc = 1'b1; end
                    5'b10000: begin par_d[4] = cmd_data_q; cnt_inc = 1'b1; end
                    5'b11111: begin par_d = '0; cnt_inc = 1'b1; end
                    default:  err_set = 1'b1;
                endcase
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cnt_d = (cnt_inc && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
        // Set has priority over a simultaneous clear.
        err_d = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cmd_mode_q <= '0;
            cmd_data_q <= '0;
            par_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_mode_q <= cmd_mode_d;
            cmd_data_q <= cmd_data_d;
            par_q      <= par_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign wr_ready = (state_q == IDLE);
    assign wr_done  = (state_q == DONE);
    assign wr_err   = err_q;
    assign wr_count = cnt_q;
    assign Q_fish   = par_q[0];
    assign Q_clean  = par_q[1];
    assign Q_temp   = par_q[2];
    assign Q_food   = par_q[3];
    assign Q_salt   = par_q[4];

endmodule
